// File: rtl/sr_reg_pkg.sv
// Shared definitions for the retention register bank.
//   ret_state_t  : save/restore controller states
//   chunk_cnt_w  : width of the chunk index for a given chunk count
package sr_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SAVING    = 2'd1,
    ST_RESTORING = 2'd2
  } ret_state_t;

  // Chunk index width; never narrower than one bit so a single-chunk
  // bank still has a legal counter.
  function automatic int chunk_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_ret_ctl.sv
// Save/restore sequencer for the retention register bank.
// Walks the chunk index 0..NCHUNK-1 once per save or restore request.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   se              : scan enable; aborts any operation back to idle
//   save, restore   : requests, sampled only in idle (save wins)
//   state           : current controller state
//   idx             : chunk being transferred this cycle
//   busy            : high whenever the controller is not idle
module sr_ret_ctl
  import sr_reg_pkg::*;
#(
  parameter int NCHUNK = 4,
  parameter int CW     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          se,
  input  logic          save,
  input  logic          restore,
  output ret_state_t    state,
  output logic [CW-1:0] idx,
  output logic          busy
);

  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (se) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (save)         state <= ST_SAVING;
          else if (restore) state <= ST_RESTORING;
        end
        ST_SAVING, ST_RESTORING: begin
          if (idx == LAST) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: rtl/sr_reg_bank.sv
// Register bank with per-bit set/clear, scan chain and chunked retention
// save/restore into an unreset shadow register.
// Ports:
//   CLK, RSTB          : clock, asynchronous active-low reset
//   D, EN              : functional load
//   SET_MASK, CLR_MASK : per-bit set / clear requests (set wins)
//   SE, SI, SO         : scan enable, scan in, scan out (= Q MSB)
//   SAVE, RESTORE      : retention requests
//   BUSY               : save or restore in progress
//   Q, QN              : register value and its inverse
module sr_reg_bank
  import sr_reg_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter int              CHUNK   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic [WIDTH-1:0] SET_MASK,
  input  logic [WIDTH-1:0] CLR_MASK,
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
  input  logic             SAVE,
  input  logic             RESTORE,
  output logic             BUSY,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = chunk_cnt_w(NCHUNK);

  ret_state_t       state;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_next;

  sr_ret_ctl #(
    .NCHUNK (NCHUNK),
    .CW     (CW)
  ) u_ctl (
    .clk     (CLK),
    .rst_n   (RSTB),
    .se      (SE),
    .save    (SAVE),
    .restore (RESTORE),
    .state   (state),
    .idx     (idx),
    .busy    (BUSY)
  );

  if (WIDTH == 1) begin : g_shift1
    assign shifted = SI;
  end else begin : g_shiftn
    assign shifted = {Q[WIDTH-2:0], SI};
  end

  // Any asserted set/clear bit turns the cycle into a mask update: masked
  // bits are forced and the rest hold, so D is only loaded on cycles with
  // no mask activity at all.
  always_comb begin
    q_next = Q;
    if (SE) begin
      q_next = shifted;
    end else begin
      case (state)
        ST_RESTORING: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (idx == CW'(k)) q_next[k*CHUNK +: CHUNK] = shadow[k*CHUNK +: CHUNK];
          end
        end
        ST_SAVING: q_next = Q;
        default: begin
          if ((|SET_MASK) || (|CLR_MASK)) q_next = (Q & ~CLR_MASK) | SET_MASK;
          else if (EN)                    q_next = D;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) Q <= RST_VAL;
    else       Q <= q_next;
  end

  // Shadow has no reset so retained contents survive RSTB; a scan abort
  // leaves already-saved chunks untouched.
  always_ff @(posedge CLK) begin
    if (!SE && state == ST_SAVING) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (idx == CW'(k)) shadow[k*CHUNK +: CHUNK] <= Q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign QN = ~Q;
  assign SO = Q[WIDTH-1];

endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic [7:0] D = '0;
  logic       EN = 1'b0;
  logic [7:0] SET_MASK = '0;
  logic [7:0] CLR_MASK = '0;
  logic       SE = 1'b0;
  logic       SI = 1'b0;
  logic       SO;
  logic       SAVE = 1'b0;
  logic       RESTORE = 1'b0;
  logic       BUSY;
  logic [7:0] Q;
  logic [7:0] QN;

  int checks = 0;
  int failures = 0;

  // Reference model: register value, shadow, current operation
  // (0 none, 1 save, 2 restore) and chunk position.
  logic [7:0] mq;
  logic [7:0] msh;
  int         mop;
  int         mk;

  sr_reg_bank #(.WIDTH(8), .CHUNK(2), .RST_VAL(8'h00)) dut (
    .CLK(CLK), .RSTB(RSTB), .D(D), .EN(EN), .SET_MASK(SET_MASK),
    .CLR_MASK(CLR_MASK), .SE(SE), .SI(SI), .SO(SO), .SAVE(SAVE),
    .RESTORE(RESTORE), .BUSY(BUSY), .Q(Q), .QN(QN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq  = 8'h00;
    mop = 0;
    mk  = 0;
  endtask

  task automatic model_edge();
    if (SE) begin
      mq  = {mq[6:0], SI};
      mop = 0;
      mk  = 0;
    end else if (mop == 2 || mop == 1) begin
      if (mop == 2) mq[mk*2 +: 2] = msh[mk*2 +: 2];
      else          msh[mk*2 +: 2] = mq[mk*2 +: 2];
      mk++;
      if (mk == 4) begin
        mop = 0;
        mk  = 0;
      end
    end else begin
      if ((SET_MASK | CLR_MASK) != 8'h00) mq = (mq & ~CLR_MASK) | SET_MASK;
      else if (EN)                        mq = D;
      if (SAVE)         mop = 1;
      else if (RESTORE) mop = 2;
    end
  endtask

  task automatic check_model(input string ph);
    logic [7:0] qn_exp;
    qn_exp = ~mq;
    chk({ph, "_q"}, 32'(Q), 32'(mq));
    chk({ph, "_qn"}, 32'(QN), 32'(qn_exp));
    chk({ph, "_busy"}, 32'(BUSY), 32'(mop != 0));
    chk({ph, "_so"}, 32'(SO), 32'(mq[7]));
  endtask

  task automatic step(input string ph);
    @(posedge CLK);
    model_edge();
    #1;
    check_model(ph);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any edge.
  task automatic mid_reset(input string ph);
    logic [7:0] qn_exp;
    #2;
    RSTB = 1'b0;
    #1;
    model_reset();
    qn_exp = ~mq;
    chk({ph, "_rst_q"}, 32'(Q), 32'(mq));
    chk({ph, "_rst_qn"}, 32'(QN), 32'(qn_exp));
    chk({ph, "_rst_busy"}, 32'(BUSY), 32'(0));
    #1;
    RSTB = 1'b1;
  endtask

  task automatic idle_inputs();
    D = '0; EN = 0; SET_MASK = '0; CLR_MASK = '0;
    SE = 0; SI = 0; SAVE = 0; RESTORE = 0;
  endtask

  task automatic load(input logic [7:0] v, input string ph);
    D = v; EN = 1;
    step(ph);
    EN = 0; D = '0;
  endtask

  initial begin
    int n;
    logic [7:0] sibits;
    model_reset();
    msh = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check_model("por");
    RSTB = 1'b1;

    // Asynchronous reset from a nonzero value
    load(8'h5A, "pre_rst");
    mid_reset("async");

    // Mask priority
    SET_MASK = 8'h0F; CLR_MASK = 8'h03; EN = 1; D = 8'hF0;
    step("mask");
    chk("mask_const", 32'(Q), 32'h0F);
    idle_inputs();

    // Save, overwrite, restore
    load(8'hA5, "ld_a5");
    SAVE = 1; step("save_req"); SAVE = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (BUSY) n++;
      step("save_run");
    end
    chk("save_busy_len", 32'(n), 32'd4);
    load(8'h00, "ld_00");
    RESTORE = 1; step("rest_req"); RESTORE = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (BUSY) n++;
      step("rest_run");
    end
    chk("rest_busy_len", 32'(n), 32'd4);
    chk("rest_a5", 32'(Q), 32'hA5);

    // Scan shift
    load(8'h00, "ld_scan");
    sibits = 8'b1011_0010;
    SE = 1;
    for (int i = 7; i >= 0; i--) begin
      SI = sibits[i];
      step("scan");
    end
    idle_inputs();
    chk("scan_b2", 32'(Q), 32'hB2);

    // Reset during restore keeps shadow
    load(8'h3C, "ld_3c");
    SAVE = 1; step("s3c_req"); SAVE = 0;
    repeat (4) step("s3c_run");
    load(8'h00, "ld_clr");
    RESTORE = 1; step("r3c_req"); RESTORE = 0;
    repeat (2) step("r3c_run");
    mid_reset("midrest");
    RESTORE = 1; step("r3c2_req"); RESTORE = 0;
    repeat (4) step("r3c2_run");
    chk("rest_3c", 32'(Q), 32'h3C);

    // Simultaneous request chooses save; scan aborts after chunk 0
    load(8'h00, "ld_z");
    SAVE = 1; step("sz_req"); SAVE = 0;
    repeat (4) step("sz_run");
    load(8'hFF, "ld_ff");
    SAVE = 1; RESTORE = 1; step("both_req"); SAVE = 0; RESTORE = 0;
    chk("both_busy", 32'(BUSY), 32'd1);
    step("both_c0");
    SE = 1; SI = 0; step("abort");
    SE = 0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    RESTORE = 1; step("pr_req"); RESTORE = 0;
    repeat (4) step("pr_run");
    chk("partial_03", 32'(Q), 32'h03);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      D        = 8'($urandom);
      EN       = 1'($urandom);
      SET_MASK = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
      CLR_MASK = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
      SE       = ($urandom_range(0, 15) == 0);
      SI       = 1'($urandom);
      SAVE     = ($urandom_range(0, 7) == 0);
      RESTORE  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) mid_reset("rnd");
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
